// File: rtl/uart_frame_rx_if.sv
// Output bundle of uart_frame_rx: per-character results and assembled frames.
// master = the receiver that drives the results, slave = downstream consumer.
interface uart_frame_rx_if #(
    parameter int DATA_BITS     = 8,
    parameter int PAYLOAD_BYTES = 3
);
    logic [DATA_BITS-1:0]       byte_data_o;
    logic                       byte_valid_o;
    logic                       byte_err_o;
    logic [8*PAYLOAD_BYTES-1:0] frame_data_o;
    logic                       frame_valid_o;
    logic                       frame_err_o;

    modport master (
        output byte_data_o, byte_valid_o, byte_err_o,
        output frame_data_o, frame_valid_o, frame_err_o
    );

    modport slave (
        input byte_data_o, byte_valid_o, byte_err_o,
        input frame_data_o, frame_valid_o, frame_err_o
    );
endinterface

// File: rtl/uart_frame_rx.sv
// UART receiver with command-frame assembler.
// Character path: IDLE -> START -> DATA -> [PARITY] -> STOP, mid-bit sampling.
// Frame path: hunts for HEADER, then packs PAYLOAD_BYTES characters into one word,
// first payload byte in the MSBs; aborts on character errors or inter-byte timeout.
// Optional feature macro UART_FRAME_CHECKSUM_EN: a trailing sum-mod-256 character
// must match before the frame is delivered.
module uart_frame_rx #(
    parameter int         CLK_FREQ      = 50000000,
    parameter int         BAUD          = 9600,
    parameter int         DATA_BITS     = 8,
    parameter int         PARITY        = 0,
    parameter logic [7:0] HEADER        = 8'hFF,
    parameter int         PAYLOAD_BYTES = 3,
    parameter int         TIMEOUT_BITS  = 20
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic uart_rx_i,
    uart_frame_rx_if.master bus
);
    localparam int BAUD_DIV  = CLK_FREQ / BAUD;
    localparam int HALF_DIV  = BAUD_DIV / 2;
    localparam int BCW       = $clog2(BAUD_DIV);
    localparam int TMO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
    localparam int TCW       = $clog2(TMO_LIMIT + 1);
    localparam int BITW      = $clog2(DATA_BITS);
    localparam int FW        = 8 * PAYLOAD_BYTES;
    localparam int CW        = $clog2(PAYLOAD_BYTES + 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} rx_state_t;
    typedef enum logic       {F_HUNT, F_COLLECT} fr_state_t;

    rx_state_t            rx_state_q, rx_state_d;
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic [BCW-1:0]       baud_q, baud_d;
    logic [BITW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic                 exp_par;
    logic                 byte_ok_d, byte_bad_d;
    logic [DATA_BITS-1:0] byte_data_q;
    logic                 byte_valid_q, byte_err_q;

    fr_state_t            fr_state_q, fr_state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [TCW-1:0]       tmo_q, tmo_d;
    logic [FW-1:0]        asm_q, asm_d, asm_next;
    logic [FW-1:0]        fdata_q, fdata_d;
    logic                 fvalid_q, fvalid_d, ferr_q, ferr_d;
    logic [7:0]           byte8;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0]           sum_q, sum_d;
`endif

    // Two-flop synchroniser plus previous sample for falling-edge detection; idle high.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Parity bit the transmitter should have sent for the shifted-in data.
    assign exp_par = (PARITY == 1) ? ~^shift_q : ^shift_q;

    // Character FSM next state; stop sample returns straight to IDLE mid-bit.
    always_comb begin
        rx_state_d = rx_state_q;
        baud_d     = baud_q + 1'b1;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        byte_ok_d  = 1'b0;
        byte_bad_d = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                baud_d    = '0;
                bit_d     = '0;
                par_err_d = 1'b0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = S_START;
            end
            S_START: if (baud_q == BCW'(HALF_DIV - 1)) begin
                baud_d     = '0;
                rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
            end
            S_DATA: if (baud_q == BCW'(BAUD_DIV - 1)) begin
                baud_d  = '0;
                shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                bit_d   = bit_q + 1'b1;
                if (bit_q == BITW'(DATA_BITS - 1))
                    rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (baud_q == BCW'(BAUD_DIV - 1)) begin
                baud_d     = '0;
                par_err_d  = (rx_sync_q != exp_par);
                rx_state_d = S_STOP;
            end
            S_STOP: if (baud_q == BCW'(BAUD_DIV - 1)) begin
                baud_d     = '0;
                byte_ok_d  = rx_sync_q && !par_err_q;
                byte_bad_d = !(rx_sync_q && !par_err_q);
                rx_state_d = S_IDLE;
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // Character FSM state and registered character outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_state_q   <= S_IDLE;
            baud_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            par_err_q    <= 1'b0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            byte_err_q   <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            par_err_q    <= par_err_d;
            byte_valid_q <= byte_ok_d;
            byte_err_q   <= byte_bad_d;
            if (byte_ok_d) byte_data_q <= shift_q;
        end
    end

    // Character zero-extended to one 8-bit payload slot.
    always_comb begin
        byte8                = '0;
        byte8[DATA_BITS-1:0] = byte_data_q;
    end

    assign asm_next = (asm_q << 8) | FW'(byte8);

    // Frame FSM next state. Character errors are taken from the stop-sample cycle so
    // frame_err lines up with byte_err; a completed byte takes priority over timeout.
    always_comb begin
        fr_state_d = fr_state_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        asm_d      = asm_q;
        fdata_d    = fdata_q;
        fvalid_d   = 1'b0;
        ferr_d     = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (fr_state_q)
            F_HUNT: begin
                cnt_d = '0;
                tmo_d = '0;
`ifdef UART_FRAME_CHECKSUM_EN
                sum_d = '0;
`endif
                if (byte_valid_q && byte_data_q == HEADER[DATA_BITS-1:0])
                    fr_state_d = F_COLLECT;
            end
            F_COLLECT: begin
                if (tmo_q != TCW'(TMO_LIMIT)) tmo_d = tmo_q + 1'b1;
                if (byte_valid_q) begin
                    tmo_d = '0;
`ifdef UART_FRAME_CHECKSUM_EN
                    if (cnt_q == CW'(PAYLOAD_BYTES)) begin
                        fr_state_d = F_HUNT;
                        if (byte8 == sum_q) begin
                            fdata_d  = asm_q;
                            fvalid_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        asm_d = asm_next;
                        sum_d = sum_q + byte8;
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    asm_d = asm_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(PAYLOAD_BYTES - 1)) begin
                        fdata_d    = asm_next;
                        fvalid_d   = 1'b1;
                        fr_state_d = F_HUNT;
                    end
`endif
                end else if (byte_bad_d || tmo_q == TCW'(TMO_LIMIT)) begin
                    ferr_d     = 1'b1;
                    fr_state_d = F_HUNT;
                end
            end
            default: fr_state_d = F_HUNT;
        endcase
    end

    // Frame FSM state, assembly register and frame outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fr_state_q <= F_HUNT;
            cnt_q      <= '0;
            tmo_q      <= '0;
            asm_q      <= '0;
            fdata_q    <= '0;
            fvalid_q   <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            fr_state_q <= fr_state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            asm_q      <= asm_d;
            fdata_q    <= fdata_d;
            fvalid_q   <= fvalid_d;
            ferr_q     <= ferr_d;
`ifdef UART_FRAME_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign bus.byte_data_o   = byte_data_q;
    assign bus.byte_valid_o  = byte_valid_q;
    assign bus.byte_err_o    = byte_err_q;
    assign bus.frame_data_o  = fdata_q;
    assign bus.frame_valid_o = fvalid_q;
    assign bus.frame_err_o   = ferr_q;
endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx: stimulus pushes expected character and frame
// events into queues, a negedge monitor pops and compares on every output pulse.
// Bit period is 16 clocks to keep runtime short; dut_b uses even parity.
module tb_uart_frame_rx;
    localparam int BD = 16;

    typedef struct {
        logic        err;
        logic [23:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;

    always #5 clk = ~clk;

    uart_frame_rx_if #(.DATA_BITS(8), .PAYLOAD_BYTES(3)) a_if ();
    uart_frame_rx_if #(.DATA_BITS(8), .PAYLOAD_BYTES(3)) b_if ();

    uart_frame_rx #(.CLK_FREQ(1600000), .BAUD(100000), .PARITY(0), .TIMEOUT_BITS(20))
        dut_a (.clk_i(clk), .rst_n_i(rst_n), .uart_rx_i(rx_a), .bus(a_if));
    uart_frame_rx #(.CLK_FREQ(1600000), .BAUD(100000), .PARITY(2), .TIMEOUT_BITS(20))
        dut_b (.clk_i(clk), .rst_n_i(rst_n), .uart_rx_i(rx_b), .bus(b_if));

    int n_chk = 0;
    int n_fail = 0;
    ev_t qa_b[$];
    ev_t qa_f[$];
    ev_t qb_b[$];
    logic [7:0]  last_a = '0;
    logic [7:0]  last_b = '0;
    logic [23:0] last_f = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input logic err, input logic [23:0] d);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got err=%b data=%h, expected no event", nm, err, d);
    endtask

    // Monitor: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        ev_t e;
        if (rst_n) begin
            if (a_if.byte_valid_o || a_if.byte_err_o) begin
                if (qa_b.size() == 0) unexpected("a_byte_extra", a_if.byte_err_o, 24'(a_if.byte_data_o));
                else begin
                    e = qa_b.pop_front();
                    chk("a_byte", {a_if.byte_valid_o, a_if.byte_err_o, a_if.byte_data_o},
                        {~e.err, e.err, e.data[7:0]});
                end
            end
            if (a_if.frame_valid_o || a_if.frame_err_o) begin
                if (qa_f.size() == 0) unexpected("a_frame_extra", a_if.frame_err_o, a_if.frame_data_o);
                else begin
                    e = qa_f.pop_front();
                    chk("a_frame", {a_if.frame_valid_o, a_if.frame_err_o, a_if.frame_data_o},
                        {~e.err, e.err, e.data});
                end
            end
            if (b_if.byte_valid_o || b_if.byte_err_o) begin
                if (qb_b.size() == 0) unexpected("b_byte_extra", b_if.byte_err_o, 24'(b_if.byte_data_o));
                else begin
                    e = qb_b.pop_front();
                    chk("b_byte", {b_if.byte_valid_o, b_if.byte_err_o, b_if.byte_data_o},
                        {~e.err, e.err, e.data[7:0]});
                end
            end
            if (b_if.frame_valid_o || b_if.frame_err_o)
                unexpected("b_frame_extra", b_if.frame_err_o, b_if.frame_data_o);
        end
    end

    task automatic bit_time();
        repeat (BD) @(negedge clk);
    endtask

    task automatic drive(input int ln, input logic v);
        if (ln == 0) rx_a = v;
        else         rx_b = v;
    endtask

    task automatic send(input int ln, input logic [7:0] d, input logic par_en,
                        input logic par, input logic stop);
        drive(ln, 1'b0);
        bit_time();
        for (int i = 0; i < 8; i++) begin
            drive(ln, d[i]);
            bit_time();
        end
        if (par_en) begin
            drive(ln, par);
            bit_time();
        end
        drive(ln, stop);
        bit_time();
        drive(ln, 1'b1);
        if (!stop) bit_time();
    endtask

    task automatic push_a_byte(input logic err, input logic [7:0] d);
        ev_t e;
        e.err  = err;
        e.data = err ? 24'(last_a) : 24'(d);
        if (!err) last_a = d;
        qa_b.push_back(e);
    endtask

    task automatic push_frame(input logic err, input logic [23:0] d);
        ev_t e;
        e.err  = err;
        e.data = err ? last_f : d;
        if (!err) last_f = d;
        qa_f.push_back(e);
    endtask

    task automatic a_byte(input logic [7:0] d);
        push_a_byte(1'b0, d);
        send(0, d, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic a_frame(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
        push_frame(1'b0, {x, y, z});
        a_byte(8'hFF);
        a_byte(x);
        a_byte(y);
        a_byte(z);
`ifdef UART_FRAME_CHECKSUM_EN
        a_byte(x + y + z);
`endif
    endtask

    task automatic b_byte(input logic [7:0] d, input logic flip);
        ev_t e;
        e.err  = flip;
        e.data = flip ? 24'(last_b) : 24'(d);
        if (!flip) last_b = d;
        qb_b.push_back(e);
        send(1, d, 1'b1, (^d) ^ flip, 1'b1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_byte_data",   24'(a_if.byte_data_o), 24'h0);
        chk("rst_byte_valid",  a_if.byte_valid_o, 0);
        chk("rst_byte_err",    a_if.byte_err_o, 0);
        chk("rst_frame_data",  a_if.frame_data_o, 24'h0);
        chk("rst_frame_valid", a_if.frame_valid_o, 0);
        chk("rst_frame_err",   a_if.frame_err_o, 0);
        bit_time();

        // basic frame, then back-to-back frame
        a_frame(8'h00, 8'h00, 8'h04);
        a_frame(8'h00, 8'h00, 8'h02);
        bit_time();

        // short low glitch while idle must produce nothing
        rx_a = 1'b0;
        repeat (3) @(negedge clk);
        rx_a = 1'b1;
        repeat (2) bit_time();
        a_frame(8'h12, 8'h34, 8'h56);
        bit_time();

        // inter-byte timeout aborts the frame
        a_byte(8'hFF);
        a_byte(8'h00);
        push_frame(1'b1, '0);
        repeat (25) bit_time();
        a_frame(8'hAA, 8'hBB, 8'hCC);
        bit_time();

        // framing error mid-frame, then header value accepted as payload
        a_byte(8'hFF);
        a_byte(8'h01);
        push_a_byte(1'b1, 8'h55);
        push_frame(1'b1, '0);
        send(0, 8'h55, 1'b0, 1'b0, 1'b0);
        bit_time();
        a_frame(8'hFF, 8'h00, 8'h01);
        bit_time();

`ifdef UART_FRAME_CHECKSUM_EN
        // checksum good, then checksum bad
        a_frame(8'h01, 8'h02, 8'h03);
        push_frame(1'b1, '0);
        a_byte(8'hFF);
        a_byte(8'h01);
        a_byte(8'h02);
        a_byte(8'h03);
        a_byte(8'h07);
        bit_time();
`endif

        // even parity on dut_b: good, flipped parity bit, good odd-weight value
        b_byte(8'h5A, 1'b0);
        b_byte(8'hC3, 1'b1);
        b_byte(8'h07, 1'b0);
        bit_time();

        // reset mid-frame discards partial state
        a_byte(8'hFF);
        a_byte(8'h11);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_frame_data", a_if.frame_data_o, 24'h0);
        chk("mid_rst_byte_data",  24'(a_if.byte_data_o), 24'h0);
        last_a = '0;
        last_f = '0;
        rst_n = 1'b1;
        bit_time();
        a_byte(8'h22);
        a_byte(8'h33);
        a_byte(8'h44);
        a_frame(8'h22, 8'h33, 8'h44);

        repeat (4) bit_time();
        chk("a_byte_q_empty",  qa_b.size(), 0);
        chk("a_frame_q_empty", qa_f.size(), 0);
        chk("b_byte_q_empty",  qb_b.size(), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
